cam_frame_writer: RTL and testbench

Downstream stage of the camera capture block. It pairs the byte stream from the capture stage (`pixel_data`/`pixel_valid`, RGB565, high byte first) into pixels and converts each to RGB332. It writes the pixels sequentially into the frame-buffer RAM through that RAM's `addr`/`data_in`/`rw`/`en` port, and signals frame completion to the display side. It arbitrates single-shot versus continuous capture and flags short or overlong frames.

---
 rtl/cam_pkg.sv | 21 ++
 rtl/pixel_packer.sv | 41 ++++
 rtl/cam_frame_writer.sv | 110 +++++++++++
 tb/tb_cam_frame_writer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera frame-buffer writer.
// Holds the default frame geometry, the FSM state type and the pixel format conversion.
package cam_pkg;

  localparam int unsigned CAM_FRAME_W  = 160;
  localparam int unsigned CAM_FRAME_H  = 120;
  localparam int unsigned FRAME_PIXELS = CAM_FRAME_W * CAM_FRAME_H;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } cam_wr_state_t;

  // Packs an RGB565 pixel (high byte first) into one RGB332 byte.
  function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/pixel_packer.sv
// Pairs capture bytes into RGB565 pixels and emits one RGB332 pixel per pair.
// The output strobe is registered, one cycle after the second byte is accepted.
module pixel_packer
  import cam_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       room,
  output logic       phase,
  output logic       pix_valid,
  output logic [7:0] pix_data
);

  logic [7:0] hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= 1'b0;
      hi        <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      pix_valid <= 1'b0;
      if (clear) begin
        phase <= 1'b0;
      end else if (byte_valid) begin
        phase <= ~phase;
        if (!phase) begin
          hi <= byte_data;
        end else if (room) begin
          pix_valid <= 1'b1;
          pix_data  <= rgb565_to_332(hi, byte_data);
        end
      end
    end
  end

endmodule

// File: rtl/cam_frame_writer.sv
// Frame writer: arms on request or continuous mode, syncs to vsync, streams pixels
// into the frame-buffer RAM and reports frame completion with short/overflow flags.
module cam_frame_writer
  import cam_pkg::*;
#(
  parameter int unsigned FRAME_W = CAM_FRAME_W,
  parameter int unsigned FRAME_H = CAM_FRAME_H,
  parameter int unsigned ADDR_W  = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic [7:0]        pixel_data,
  input  logic              pixel_valid,
  input  logic              frame_done,
  input  logic              capture_req,
  input  logic              continuous,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data_in,
  output logic              rw,
  output logic              en,
  output logic              busy,
  output logic              frame_ready,
  output logic              short_frame,
  output logic              overflow
);

  localparam int unsigned       CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  PIX_LIMIT = CNT_W'(FRAME_W * FRAME_H);

  cam_wr_state_t    state;
  logic             vsync_q;
  logic [CNT_W-1:0] count;
  logic             vsync_rise;
  logic             byte_ok;
  logic             phase;
  logic             last_byte;
  logic             room;

  assign vsync_rise = vsync & ~vsync_q;
  assign byte_ok    = (state == ST_CAPTURE) && pixel_valid;
  assign last_byte  = byte_ok && phase;
  assign room       = count < PIX_LIMIT;
  assign rw         = en;

  pixel_packer u_packer (
    .clk        (clk),
    .rst        (reset),
    .clear      (state != ST_CAPTURE),
    .byte_valid (byte_ok),
    .byte_data  (pixel_data),
    .room       (room),
    .phase      (phase),
    .pix_valid  (en),
    .pix_data   (data_in)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      vsync_q     <= 1'b0;
      count       <= '0;
      addr        <= '0;
      busy        <= 1'b0;
      frame_ready <= 1'b0;
      short_frame <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      frame_ready <= 1'b0;
      // The counter trails the write by a cycle, so addr is captured when the write is issued.
      if (en) count <= count + CNT_W'(1);
      if (last_byte && room)  addr     <= count[ADDR_W-1:0];
      if (last_byte && !room) overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (capture_req || continuous) begin
            state <= ST_ARMED;
            busy  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (vsync_rise) begin
            state       <= ST_CAPTURE;
            count       <= '0;
            addr        <= '0;
            short_frame <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (frame_done) begin
            state <= ST_DONE;
            busy  <= 1'b0;
          end else if (vsync_rise) begin
            state <= ST_ARMED;
          end
        end
        ST_DONE: begin
          // A write may still be in flight from a pixel completed alongside frame_done.
          state       <= ST_IDLE;
          frame_ready <= 1'b1;
          short_frame <= (count + CNT_W'(en)) < PIX_LIMIT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer: single-shot, continuous, overflow, short, abort and reset cases.
module tb_cam_frame_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic [7:0]  pixel_data;
  logic        pixel_valid;
  logic        frame_done;
  logic        capture_req;
  logic        continuous;
  logic [16:0] addr;
  logic [7:0]  data_in;
  logic        rw;
  logic        en;
  logic        busy;
  logic        frame_ready;
  logic        short_frame;
  logic        overflow;

  int unsigned passed = 0;
  int unsigned total  = 0;

  int unsigned wr_cnt, addr_err, rw_err, fr_cnt;
  logic [16:0] last_addr, max_addr;
  logic [16:0] wa [4];
  logic [7:0]  wd [4];

  cam_frame_writer #(.FRAME_W(160), .FRAME_H(120), .ADDR_W(17)) dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .frame_done  (frame_done),
    .capture_req (capture_req),
    .continuous  (continuous),
    .addr        (addr),
    .data_in     (data_in),
    .rw          (rw),
    .en          (en),
    .busy        (busy),
    .frame_ready (frame_ready),
    .short_frame (short_frame),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Write monitor: expected address of the n-th write in a frame is n.
  always @(negedge clk) begin
    if (!reset) begin
      if (rw !== en) rw_err++;
      if (en === 1'b1) begin
        if (addr !== 17'(wr_cnt)) addr_err++;
        if (wr_cnt < 4) begin
          wa[wr_cnt] = addr;
          wd[wr_cnt] = data_in;
        end
        last_addr = addr;
        if (addr > max_addr) max_addr = addr;
        wr_cnt++;
      end
      if (frame_ready === 1'b1) fr_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_cnt = 0; addr_err = 0; rw_err = 0;
    last_addr = '0; max_addr = '0;
  endtask

  task automatic arm(input bit use_req);
    if (use_req) begin
      capture_req = 1'b1;
      tick();
      capture_req = 1'b0;
    end
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    pixel_data  = b;
    pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic stream(input int unsigned nbytes, input int unsigned drop_at);
    for (int unsigned i = 0; i < nbytes; i++) begin
      if (i == drop_at) continuous = 1'b0;
      pixel_data  = 8'(i);
      pixel_valid = 1'b1;
      tick();
    end
    pixel_valid = 1'b0;
  endtask

  task automatic close_frame(output logic fr1, output logic fr2);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    @(negedge clk) fr1 = frame_ready;
    @(negedge clk) fr2 = frame_ready;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vsync       = 1'($urandom);
      pixel_data  = 8'($urandom);
      pixel_valid = 1'($urandom);
      frame_done  = 1'($urandom);
      capture_req = 1'($urandom);
      continuous  = 1'($urandom);
      @(negedge clk);
      outs = {addr, data_in, rw, en, busy, frame_ready, short_frame, overflow};
      total++;
      if (outs !== 32'h0) $display("FAIL reset_outputs: got %h want 0", outs);
      else passed++;
    end
    capture_req = 1'b0; continuous = 1'b0; frame_done = 1'b0;
    vsync = 1'b0; pixel_valid = 1'b0;
    tick();
    reset = 1'b0;
    clear_mon();
    fr_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      vsync       = 1'($urandom);
      pixel_data  = 8'($urandom);
      pixel_valid = 1'($urandom);
      frame_done  = 1'($urandom);
      tick();
    end
    vsync = 1'b0; pixel_valid = 1'b0; frame_done = 1'b0;
    tick();
    total++;
    if (wr_cnt != 0) $display("FAIL idle_no_writes: got %0d want 0", wr_cnt);
    else passed++;
    total++;
    if (busy !== 1'b0 || fr_cnt != 0) $display("FAIL idle_quiet: busy %b fr %0d want 0 0", busy, fr_cnt);
    else passed++;
  endtask

  task automatic test_single_shot();
    logic fr1, fr2;
    clear_mon();
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL armed_busy: got %b want 1", busy);
    else passed++;
    tick();
    vsync = 1'b1; tick(); vsync = 1'b0;
    send_byte(8'hF8); send_byte(8'h00);
    send_byte(8'h07); send_byte(8'hE0);
    @(negedge clk);
    total++;
    if (en !== 1'b1 || rw !== 1'b1 || addr !== 17'd1 || data_in !== 8'h1C)
      $display("FAIL write_latency: en %b rw %b addr %0d data %h want 1 1 1 1c", en, rw, addr, data_in);
    else passed++;
    tick();
    total++;
    if (en !== 1'b0) $display("FAIL write_one_cycle: en %b want 0", en);
    else passed++;
    total++;
    if (wr_cnt != 2 || wa[0] !== 17'd0 || wd[0] !== 8'hE0)
      $display("FAIL basic_first_write: cnt %0d addr %0d data %h want 2 0 e0", wr_cnt, wa[0], wd[0]);
    else passed++;
    close_frame(fr1, fr2);
    total++;
    if (fr1 !== 1'b0 || fr2 !== 1'b1) $display("FAIL basic_frame_ready: got %b%b want 01", fr1, fr2);
    else passed++;
    total++;
    if (short_frame !== 1'b1 || overflow !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_flags: short %b ovf %b busy %b want 1 0 0", short_frame, overflow, busy);
    else passed++;
  endtask

  task automatic test_full_frame();
    logic fr1, fr2;
    clear_mon();
    continuous = 1'b1;
    arm(1'b0);
    stream(38400, 32'hFFFF_FFFF);
    close_frame(fr1, fr2);
    total++;
    if (wr_cnt != 19200 || last_addr !== 17'd19199 || addr_err != 0 || rw_err != 0)
      $display("FAIL full_writes: cnt %0d last %0d aerr %0d rwerr %0d want 19200 19199 0 0",
               wr_cnt, last_addr, addr_err, rw_err);
    else passed++;
    total++;
    if (fr1 !== 1'b0 || fr2 !== 1'b1) $display("FAIL full_frame_ready: got %b%b want 01", fr1, fr2);
    else passed++;
    total++;
    if (short_frame !== 1'b0 || overflow !== 1'b0)
      $display("FAIL full_flags: short %b ovf %b want 0 0", short_frame, overflow);
    else passed++;
    total++;
    if (busy !== 1'b1) $display("FAIL continuous_rearm: busy %b want 1", busy);
    else passed++;
    clear_mon();
    arm(1'b0);
    send_byte(8'hFF); send_byte(8'hFF);
    @(negedge clk);
    total++;
    if (en !== 1'b1 || addr !== 17'd0 || data_in !== 8'hFF)
      $display("FAIL next_frame_addr0: en %b addr %0d data %h want 1 0 ff", en, addr, data_in);
    else passed++;
    tick();
    close_frame(fr1, fr2);
    total++;
    if (fr2 !== 1'b1 || short_frame !== 1'b1) $display("FAIL tiny_frame: fr %b short %b want 1 1", fr2, short_frame);
    else passed++;
  endtask

  task automatic test_overflow();
    logic fr1, fr2;
    clear_mon();
    arm(1'b0);
    stream(38420, 20000);
    close_frame(fr1, fr2);
    total++;
    if (wr_cnt != 19200 || max_addr !== 17'd19199 || addr_err != 0)
      $display("FAIL ovf_writes: cnt %0d max %0d aerr %0d want 19200 19199 0", wr_cnt, max_addr, addr_err);
    else passed++;
    total++;
    if (overflow !== 1'b1 || short_frame !== 1'b0 || fr2 !== 1'b1)
      $display("FAIL ovf_flags: ovf %b short %b fr %b want 1 0 1", overflow, short_frame, fr2);
    else passed++;
    tick();
    total++;
    if (busy !== 1'b0) $display("FAIL continuous_dropped: busy %b want 0", busy);
    else passed++;
  endtask

  task automatic test_short();
    logic fr1, fr2;
    clear_mon();
    arm(1'b1);
    stream(201, 32'hFFFF_FFFF);
    close_frame(fr1, fr2);
    total++;
    if (wr_cnt != 100 || last_addr !== 17'd99)
      $display("FAIL short_writes: cnt %0d last %0d want 100 99", wr_cnt, last_addr);
    else passed++;
    total++;
    if (short_frame !== 1'b1 || overflow !== 1'b0 || fr2 !== 1'b1)
      $display("FAIL short_flags: short %b ovf %b fr %b want 1 0 1", short_frame, overflow, fr2);
    else passed++;
  endtask

  task automatic test_coincident_done();
    clear_mon();
    arm(1'b1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hE5);
    pixel_data = 8'h18; pixel_valid = 1'b1; frame_done = 1'b1;
    tick();
    pixel_valid = 1'b0; frame_done = 1'b0;
    @(negedge clk);
    total++;
    if (en !== 1'b1 || addr !== 17'd1 || data_in !== 8'hF7 || frame_ready !== 1'b0)
      $display("FAIL coincident_write: en %b addr %0d data %h fr %b want 1 1 f7 0", en, addr, data_in, frame_ready);
    else passed++;
    @(negedge clk);
    total++;
    if (frame_ready !== 1'b1 || short_frame !== 1'b1)
      $display("FAIL coincident_ready: fr %b short %b want 1 1", frame_ready, short_frame);
    else passed++;
    tick();
    total++;
    if (wr_cnt != 2 || wd[0] !== 8'h0A) $display("FAIL coincident_count: cnt %0d d0 %h want 2 0a", wr_cnt, wd[0]);
    else passed++;
  endtask

  task automatic test_abort();
    logic fr1, fr2;
    int unsigned fr_snap;
    clear_mon();
    fr_snap = fr_cnt;
    arm(1'b1);
    stream(6, 32'hFFFF_FFFF);
    tick();
    vsync = 1'b1; tick(); vsync = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (fr_cnt != fr_snap || busy !== 1'b1 || wr_cnt != 3)
      $display("FAIL abort_no_ready: fr %0d busy %b wr %0d want %0d 1 3", fr_cnt, busy, wr_cnt, fr_snap);
    else passed++;
    vsync = 1'b1; tick(); vsync = 1'b0;
    send_byte(8'h00); send_byte(8'h18);
    @(negedge clk);
    total++;
    if (en !== 1'b1 || addr !== 17'd0 || data_in !== 8'h03)
      $display("FAIL abort_restart: en %b addr %0d data %h want 1 0 03", en, addr, data_in);
    else passed++;
    tick();
    close_frame(fr1, fr2);
    total++;
    if (fr2 !== 1'b1 || fr_cnt != fr_snap + 1)
      $display("FAIL abort_single_ready: fr %b count %0d want 1 %0d", fr2, fr_cnt, fr_snap + 1);
    else passed++;
  endtask

  task automatic test_reset_mid_write();
    arm(1'b1);
    send_byte(8'h11); send_byte(8'h22);
    total++;
    if (en !== 1'b1) $display("FAIL midwrite_en_high: en %b want 1", en);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if (en !== 1'b0 || rw !== 1'b0 || busy !== 1'b0 || addr !== 17'd0)
      $display("FAIL midwrite_async_reset: en %b rw %b busy %b addr %0d want 0 0 0 0", en, rw, busy, addr);
    else passed++;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0; vsync = 1'b0; pixel_data = '0; pixel_valid = 1'b0;
    frame_done = 1'b0; capture_req = 1'b0; continuous = 1'b0;
    fr_cnt = 0;
    clear_mon();
    #2;
    test_reset();
    test_single_shot();
    test_full_frame();
    test_overflow();
    test_short();
    test_coincident_done();
    test_abort();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
